// File: rtl/axi_ar_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_ar_router: AXI read-address router with a base/mask address map and a  |
// | local DECERR responder for requests that hit no window.  Revision 1.0       |
// +----------------------------------------------------------------------------+
module axi_ar_router #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_PORT_NUM   = 3,
  parameter logic [AXI_PORT_NUM*AXI_ADDR_WIDTH-1:0] ADDR_BASE =
    {32'h4000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [AXI_PORT_NUM*AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    {32'hC000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      s_arvalid_i,
  output logic                      s_arready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [AXI_ID_WIDTH-1:0]   s_arid_i,
  input  logic [7:0]                s_arlen_i,
  output logic [AXI_PORT_NUM-1:0]   m_arvalid_o,
  input  logic [AXI_PORT_NUM-1:0]   m_arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [AXI_ID_WIDTH-1:0]   m_arid_o,
  output logic [7:0]                m_arlen_o,
  output logic                      err_rvalid_o,
  input  logic                      err_rready_i,
  output logic [AXI_ID_WIDTH-1:0]   err_rid_o,
  output logic                      err_rlast_o,
  output logic [1:0]                err_rresp_o,
  output logic [AXI_PORT_NUM-1:0]   trgt_o,
  output logic [CNT_WIDTH-1:0]      misroute_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [1:0]           c_decerr  = 2'b11;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                beat_q, beat_d;
  logic [AXI_PORT_NUM-1:0]   trgt_q, trgt_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic [AXI_PORT_NUM-1:0]   w_hit;
  logic [AXI_PORT_NUM-1:0]   w_sel;
  logic                      w_fwd_done;
  logic                      w_last;

  for (genvar i = 0; i < AXI_PORT_NUM; i++) begin : g_hit
    assign w_hit[i] = (s_araddr_i & ADDR_MASK[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH])
                      == ADDR_BASE[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign w_sel      = w_hit & (-w_hit);
  assign w_fwd_done = |(m_arready_i & trgt_q);
  assign w_last     = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    trgt_d  = trgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_arvalid_i) begin
          addr_d = s_araddr_i;
          id_d   = s_arid_i;
          len_d  = s_arlen_i;
          trgt_d = w_sel;
          if (|w_sel) begin
            state_d = FWD;
          end else begin
            state_d = ERR;
            beat_d  = 8'd0;
            if (cnt_q != c_cnt_max) cnt_d = cnt_q + c_cnt_one;
          end
        end
      end
      FWD: begin
        if (w_fwd_done) begin
          state_d = IDLE;
          trgt_d  = '0;
        end
      end
      ERR: begin
        if (err_rready_i) begin
          if (w_last) state_d = IDLE;
          else        beat_d  = beat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      trgt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      trgt_q  <= trgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is masked by reset so nothing is accepted while rst_i is held.
  assign s_arready_o    = (state_q == IDLE) & ~rst_i;
  assign m_arvalid_o    = (state_q == FWD) ? trgt_q : '0;
  assign m_araddr_o     = addr_q;
  assign m_arid_o       = id_q;
  assign m_arlen_o      = len_q;
  assign err_rvalid_o   = (state_q == ERR);
  assign err_rid_o      = id_q;
  assign err_rlast_o    = (state_q == ERR) & w_last;
  assign err_rresp_o    = c_decerr;
  assign trgt_o         = trgt_q;
  assign misroute_cnt_o = cnt_q;

endmodule
`default_nettype wire
